// File: rtl/ext_mem_loader_pkg.sv
// Shared types for the external-memory loader.
// State encoding and the fixed phase order of a run.
package ext_mem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_I,
      S_LD_D,
      S_RUN,
      S_RD_REQ,
      S_RD_WAIT,
      S_RD_OUT,
      S_FIN
   } state_t;

   // nz bit order: {dump, run, load data, load instr}
   function automatic state_t next_phase(input state_t cur,
                                         input logic [3:0] nz);
      logic [3:0] m;
      state_t     nxt;
      unique case (cur)
         S_IDLE:  m = 4'b1111;
         S_LD_I:  m = 4'b1110;
         S_LD_D:  m = 4'b1100;
         S_RUN:   m = 4'b1000;
         default: m = 4'b0000;
      endcase
      m = m & nz;
      priority case (1'b1)
         m[0]:    nxt = S_LD_I;
         m[1]:    nxt = S_LD_D;
         m[2]:    nxt = S_RUN;
         m[3]:    nxt = S_RD_REQ;
         default: nxt = S_FIN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ext_mem_seq_counter.sv
// Loadable up/down counter with terminal-count compare.
// Used for word indexing and for the run-cycle countdown.
import ext_mem_loader_pkg::*;

module ext_mem_seq_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         up,
   input  logic [W-1:0] tc_val,
   output logic [W-1:0] cnt,
   output logic         tc
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en) cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low reset.
// Holds q until en is asserted.
module reg_arstn_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side loader: streams program/data into the core memories,
// runs the core for a set number of cycles, then dumps data memory.
import ext_mem_loader_pkg::*;

module ext_mem_loader #(
   parameter int IMEM_ADDR_W = 9,
   parameter int DMEM_ADDR_W = 10,
   parameter int RUN_W       = 32
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   start,
   input  logic [IMEM_ADDR_W:0]   imem_len,
   input  logic [DMEM_ADDR_W:0]   dmem_len,
   input  logic [RUN_W-1:0]       run_cycles,
   input  logic [DMEM_ADDR_W:0]   dump_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [63:0]            in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [63:0]            out_data,
   output logic                   cpu_enable,
   output logic [63:0]            addr_ext,
   output logic                   wen_ext,
   output logic                   ren_ext,
   output logic [31:0]            wdata_ext,
   input  logic [31:0]            rdata_ext,
   output logic [63:0]            addr_ext_2,
   output logic                   wen_ext_2,
   output logic                   ren_ext_2,
   output logic [63:0]            wdata_ext_2,
   input  logic [63:0]            rdata_ext_2,
   output logic                   busy,
   output logic                   done
);

   localparam int CNT_W =
      (IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W;
   localparam logic [IMEM_ADDR_W:0] I_CAP =
      {1'b1, {IMEM_ADDR_W{1'b0}}};
   localparam logic [DMEM_ADDR_W:0] D_CAP =
      {1'b1, {DMEM_ADDR_W{1'b0}}};

   state_t                 state;
   logic [IMEM_ADDR_W:0]   ilen;
   logic [DMEM_ADDR_W:0]   dlen;
   logic [DMEM_ADDR_W:0]   olen;
   logic                   run_nz;
   logic [3:0]             nz;
   logic [3:0]             nz_c;
   logic [IMEM_ADDR_W:0]   ilen_c;
   logic [DMEM_ADDR_W:0]   dlen_c;
   logic [DMEM_ADDR_W:0]   olen_c;

   logic                   start_fire;
   logic                   in_fire;
   logic                   out_fire;
   logic                   ld_i;
   logic                   ld_d;
   logic [CNT_W:0]         wlen;
   logic [CNT_W:0]         wlen_m1;
   logic [CNT_W-1:0]       w_cnt;
   logic                   w_tc;
   logic                   w_en;
   logic [RUN_W-1:0]       r_cnt;
   logic                   r_tc;
   logic                   unused;

   assign ilen_c = (imem_len > I_CAP) ? I_CAP : imem_len;
   assign dlen_c = (dmem_len > D_CAP) ? D_CAP : dmem_len;
   assign olen_c = (dump_len > D_CAP) ? D_CAP : dump_len;
   assign nz_c   = {olen_c != '0, run_cycles != '0,
                    dlen_c != '0, ilen_c != '0};
   assign nz     = {olen != '0, run_nz, dlen != '0, ilen != '0};

   assign ld_i       = (state == S_LD_I);
   assign ld_d       = (state == S_LD_D);
   assign start_fire = (state == S_IDLE) && start;
   assign in_ready   = ld_i || ld_d;
   assign in_fire    = in_ready && in_valid;
   assign out_valid  = (state == S_RD_OUT);
   assign out_fire   = out_valid && out_ready;
   assign cpu_enable = (state == S_RUN);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_FIN);

   always_comb begin
      wlen = (CNT_W+1)'(olen);
      if (ld_i) wlen = (CNT_W+1)'(ilen);
      else if (ld_d) wlen = (CNT_W+1)'(dlen);
   end

   assign wlen_m1 = wlen - 1'b1;
   assign w_en    = in_fire || out_fire;

   ext_mem_seq_counter #(.W(CNT_W)) u_word_cnt (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (start_fire || (w_en && w_tc)),
      .load_val ('0),
      .en       (w_en),
      .up       (1'b1),
      .tc_val   (wlen_m1[CNT_W-1:0]),
      .cnt      (w_cnt),
      .tc       (w_tc)
   );

   ext_mem_seq_counter #(.W(RUN_W)) u_run_cnt (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (start_fire),
      .load_val (run_cycles),
      .en       (cpu_enable),
      .up       (1'b0),
      .tc_val   (RUN_W'(1)),
      .cnt      (r_cnt),
      .tc       (r_tc)
   );

   reg_arstn_en #(.W(64)) u_out_reg (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (state == S_RD_WAIT),
      .d      (rdata_ext_2),
      .q      (out_data)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state  <= S_IDLE;
         ilen   <= '0;
         dlen   <= '0;
         olen   <= '0;
         run_nz <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (start) begin
               ilen   <= ilen_c;
               dlen   <= dlen_c;
               olen   <= olen_c;
               run_nz <= nz_c[2];
               state  <= next_phase(S_IDLE, nz_c);
            end
            S_LD_I: if (in_fire && w_tc)
               state <= next_phase(S_LD_I, nz);
            S_LD_D: if (in_fire && w_tc)
               state <= next_phase(S_LD_D, nz);
            S_RUN: if (r_tc)
               state <= next_phase(S_RUN, nz);
            S_RD_REQ:  state <= S_RD_WAIT;
            S_RD_WAIT: state <= S_RD_OUT;
            S_RD_OUT: if (out_fire)
               state <= w_tc ? S_FIN : S_RD_REQ;
            S_FIN:     state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Writes are presented combinationally in the handshake cycle
   assign wen_ext   = ld_i && in_valid;
   assign ren_ext   = 1'b0;
   assign wdata_ext = wen_ext ? in_data[31:0] : '0;
   assign addr_ext  = wen_ext ?
      64'({w_cnt[IMEM_ADDR_W-1:0], 2'b00}) : '0;

   assign wen_ext_2   = ld_d && in_valid;
   assign ren_ext_2   = (state == S_RD_REQ);
   assign wdata_ext_2 = wen_ext_2 ? in_data : '0;
   assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ?
      64'({w_cnt[DMEM_ADDR_W-1:0], 3'b000}) : '0;

   assign unused = ^{rdata_ext, wlen_m1[CNT_W], r_cnt[0]};

endmodule

// File: doc/ext_mem_loader.md
# ext_mem_loader

Host-side controller that drives the processor's external memory ports: the initiator for the instruction- and data-memory `*_ext` / `*_ext_2` access ports, whose responder is the core's memories. A run has three phases. First it streams a program and an initial data image in through a valid/ready input. Next it holds the core `enable` high for a programmed number of cycles. Last it reads back a window of data memory and streams it out through a valid/ready output. It sits between the testbench/host link and `cpu`, and is the only agent driving the ext ports.

## Interface
- IMEM_ADDR_W, 9: instruction memory word-address width; capacity 2^IMEM_ADDR_W 32-bit words
- DMEM_ADDR_W, 10: data memory word-address width; capacity 2^DMEM_ADDR_W 64-bit words
- RUN_W, 32: width of run-cycle counter

- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sequence; sampled in IDLE only
- imem_len  in  IMEM_ADDR_W+1  32-bit words to load; sampled at start
- dmem_len  in  DMEM_ADDR_W+1  64-bit words to load; sampled at start
- run_cycles  in  RUN_W  cycles of cpu_enable; sampled at start
- dump_len  in  DMEM_ADDR_W+1  64-bit words to read back from byte address 0; sampled at start
- in_valid / in_ready  in / out  1  load-stream handshake
- in_data  in  64  load word; bits [31:0] used in instruction phase
- out_valid / out_ready  out / in  1  dump-stream handshake
- out_data  out  64  dumped data-memory word
- cpu_enable  out  1  to core `enable`
- addr_ext, wen_ext, ren_ext, wdata_ext[31:0]  out  to instruction memory ext port (addr 64 bits)
- rdata_ext  in  32  unused; no read of instruction memory
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2[63:0]  out  to data memory ext port (addr 64 bits)
- rdata_ext_2  in  64  data memory read data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of sequence

## Operation
- States: IDLE, LD_I, LD_D, RUN, RD_REQ, RD_WAIT, RD_OUT, FIN.
- IDLE
  - start=1: latch the four lengths, clamping each to memory capacity.
  - Clear the word counter and go to the first phase whose length is nonzero, in order LD_I, LD_D, RUN, RD_REQ; otherwise go to FIN.
- LD_I
  - in_ready=1.
  - On in_valid&&in_ready: wen_ext=1, addr_ext={cnt,2'b00} zero-extended (byte address 4k), wdata_ext=in_data[31:0], cnt++.
  - After imem_len words: cnt←0, go to the next nonzero phase.
- LD_D
  - Same as LD_I on port 2, with addr_ext_2={cnt,3'b000} (byte address 8k) and wdata_ext_2=in_data.
- RUN
  - cpu_enable=1 for exactly run_cycles consecutive cycles, then the next phase.
  - All ext write/read enables are 0 throughout.
- RD_REQ
  - ren_ext_2=1, addr_ext_2={cnt,3'b000}, go to RD_WAIT.
- RD_WAIT
  - Capture rdata_ext_2 into the out register, go to RD_OUT.
- RD_OUT
  - out_valid=1, out_data stable until out_ready.
  - On handshake: cnt++; if cnt==dump_len then FIN, else RD_REQ.
- FIN
  - done=1 for one cycle, then IDLE.
- Outside their phase, wen_ext/ren_ext/wen_ext_2/ren_ext_2/in_ready/out_valid/cpu_enable are 0.
- Address and wdata outputs are 0 whenever their enable is 0.
- cpu_enable and every ext enable are never high in the same cycle.
- start while busy is ignored.
- Length inputs may change while busy without effect.

## Timing
- Reset: state IDLE; all outputs and counters 0.
  - Reset mid-sequence aborts immediately; memory contents written so far are left as is.
- Write latency: the write is presented combinationally in the cycle of the handshake; the memory commits on that clock edge.
  - Throughput is 1 word/cycle with in_valid held high.
- Read latency: rdata_ext_2 is valid the cycle after ren_ext_2.
  - Dump throughput is 1 word per 3 cycles with out_ready held high; out_ready low stalls in RD_OUT indefinitely.
- start in IDLE → busy=1 the next cycle.
- First cpu_enable cycle = first cycle in RUN; last cpu_enable cycle is followed by the RD_REQ cycle, in which cpu_enable=0.
- Counter wrap: not possible because lengths are clamped; len=capacity loads exactly every word (addresses 0..capacity-1).

## Structure
- Shared package holds the state enum and the phase order; no other shared types.
- One sub-module, `ext_mem_seq_counter`: a loadable down/up counter with terminal-count flag, instantiated once for words and once for run cycles.
- Existing `reg_arstn_en` is reused for the out_data capture register.

## Test plan
- Reset mid-LD_D (after 3 of 8 words) → all outputs 0 next cycle, busy=0; a new start then completes normally.
- imem_len=4, dmem_len=2, run_cycles=0, dump_len=2, data words 0x13,0x93,0x113,0x193 then 0xA, 0xB:
  - wen_ext pulses at addr 0,4,8,12.
  - wen_ext_2 pulses at addr 0,8.
  - Dump emits 0xA then 0xB.
  - done pulses once.
- in_valid toggling 1/0 every cycle during LD_I (8 words) → exactly 8 writes at addr 0..28; no write in cycles where in_valid=0.
- run_cycles=5, all lengths 0 → cpu_enable high for exactly 5 cycles; no ext enable ever high; done 1 cycle after the last enable cycle.
- dump_len=3 with out_ready low for 10 cycles on word 1 → out_data holds word 1 stable; ren_ext_2 not reasserted until the handshake; output order is 0,1,2.
- imem_len=600 (>512) → exactly 512 writes, last at addr 2044; start asserted while busy has no effect.
